// File: rtl/dtree_seq_engine_if.sv
// Bus bundle for dtree_seq_engine: feature-vector input handshake, result
// output handshake and the node-table configuration port.
//   master : feature source / class consumer / configuration agent
//   slave  : the engine
// Port summary (slave view):
//   in_valid, in_feat -> in ;  in_ready -> out
//   out_ready         -> in ;  out_valid, out_class, out_depth, out_err -> out
//   cfg_we, cfg_addr, cfg_data -> in ;  cfg_rej -> out
interface dtree_seq_engine_if #(
  parameter int unsigned NFEAT     = 4,
  parameter int unsigned FW        = 8,
  parameter int unsigned CW        = 3,
  parameter int unsigned NODES     = 16,
  parameter int unsigned MAX_DEPTH = 8
);
  localparam int unsigned AW  = $clog2(NODES);
  localparam int unsigned IW  = (NFEAT > 1) ? $clog2(NFEAT) : 1;
  localparam int unsigned NDW = 1 + IW + FW + 2 * AW;
  localparam int unsigned DW  = $clog2(MAX_DEPTH + 1);

  logic                  in_valid;
  logic                  in_ready;
  logic [NFEAT*FW-1:0]   in_feat;
  logic                  out_valid;
  logic                  out_ready;
  logic [CW-1:0]         out_class;
  logic [DW-1:0]         out_depth;
  logic                  out_err;
  logic                  cfg_we;
  logic [AW-1:0]         cfg_addr;
  logic [NDW-1:0]        cfg_data;
  logic                  cfg_rej;

  modport master (
    output in_valid, in_feat, out_ready, cfg_we, cfg_addr, cfg_data,
    input  in_ready, out_valid, out_class, out_depth, out_err, cfg_rej
  );

  modport slave (
    input  in_valid, in_feat, out_ready, cfg_we, cfg_addr, cfg_data,
    output in_ready, out_valid, out_class, out_depth, out_err, cfg_rej
  );
endinterface

// File: rtl/dtree_seq_engine.sv
// Sequential decision-tree classifier. A feature vector is captured on the
// input handshake, then the runtime-loaded node table is walked one node per
// clock from root node 0 until a leaf, a depth-limit abort or a bad index.
// The result (class, comparisons taken, error flag) is held on the output
// handshake until consumed.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset (clears FSM, outputs, node table)
//   bus   - dtree_seq_engine_if.slave: in_*/out_* handshakes and cfg_* port
// Node word, MSB to LSB: {leaf, fidx[IW], thr[FW], left[AW], right[AW]}.
module dtree_seq_engine #(
  parameter int unsigned NFEAT     = 4,
  parameter int unsigned FW        = 8,
  parameter int unsigned CW        = 3,
  parameter int unsigned NODES     = 16,
  parameter int unsigned MAX_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  dtree_seq_engine_if.slave bus
);
  localparam int unsigned AW  = $clog2(NODES);
  localparam int unsigned IW  = (NFEAT > 1) ? $clog2(NFEAT) : 1;
  localparam int unsigned NDW = 1 + IW + FW + 2 * AW;
  localparam int unsigned DW  = $clog2(MAX_DEPTH + 1);

  // When an index field exactly spans its range no out-of-range value exists.
  localparam bit FIDX_FULL  = (NFEAT == (32'd1 << IW));
  localparam bit NODES_FULL = (NODES == (32'd1 << AW));

  // Cleared node: leaf with thr=0, i.e. class 0.
  localparam logic [NDW-1:0] NODE_RST = {1'b1, {(NDW-1){1'b0}}};

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WALK = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [NDW-1:0] node_tab [NODES];
  logic [FW-1:0]  feat_q   [NFEAT];
  logic           feat_ld;

  logic [AW-1:0]  cur_q, cur_d;
  logic [DW-1:0]  depth_q, depth_d;
  logic [CW-1:0]  class_q, class_d;
  logic [DW-1:0]  dout_q, dout_d;
  logic           err_q, err_d;
  logic           oval_q, oval_d;
  logic           irdy_q, irdy_d;
  logic           rej_q, rej_d;

  // Current node decode
  logic [NDW-1:0] node_w;
  logic           node_leaf;
  logic [IW-1:0]  node_fidx;
  logic [FW-1:0]  node_thr;
  logic [AW-1:0]  node_left;
  logic [AW-1:0]  node_right;
  logic [FW-1:0]  feat_sel;
  logic [AW-1:0]  next_addr;
  logic           fidx_bad;
  logic           child_bad;
  logic           cfg_addr_bad;
  logic           cfg_wr_ok;

  assign node_w     = node_tab[cur_q];
  assign node_leaf  = node_w[NDW-1];
  assign node_fidx  = node_w[NDW-2 -: IW];
  assign node_thr   = node_w[2*AW +: FW];
  assign node_left  = node_w[AW +: AW];
  assign node_right = node_w[0 +: AW];

  // Feature mux; an out-of-range fidx selects 0 and is flagged separately.
  always_comb begin
    feat_sel = '0;
    for (int i = 0; i < NFEAT; i++) begin
      if (node_fidx == IW'(i)) feat_sel = feat_q[i];
    end
  end

  assign next_addr = (feat_sel <= node_thr) ? node_left : node_right;

  generate
    if (FIDX_FULL) begin : g_fidx_full
      assign fidx_bad = 1'b0;
    end else begin : g_fidx_chk
      assign fidx_bad = (32'(node_fidx) >= NFEAT);
    end

    if (NODES_FULL) begin : g_nodes_full
      assign child_bad    = 1'b0;
      assign cfg_addr_bad = 1'b0;
    end else begin : g_nodes_chk
      assign child_bad    = (32'(next_addr) >= NODES);
      assign cfg_addr_bad = (32'(bus.cfg_addr) >= NODES);
    end
  endgenerate

  // Writes land only while idle; a write alongside an accept is seen by that walk.
  assign cfg_wr_ok = bus.cfg_we && (state_q == IDLE) && !cfg_addr_bad;

  // Node table
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NODES; i++) node_tab[i] <= NODE_RST;
    end else if (cfg_wr_ok) begin
      node_tab[bus.cfg_addr] <= bus.cfg_data;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and registered-output next values
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    depth_d = depth_q;
    class_d = class_q;
    dout_d  = dout_q;
    err_d   = err_q;
    oval_d  = oval_q;
    irdy_d  = irdy_q;
    feat_ld = 1'b0;
    rej_d   = bus.cfg_we && !cfg_wr_ok;

    case (state_q)
      IDLE: begin
        irdy_d = 1'b1;
        if (bus.in_valid && irdy_q) begin
          feat_ld = 1'b1;
          cur_d   = '0;
          depth_d = '0;
          irdy_d  = 1'b0;
          state_d = WALK;
        end
      end

      WALK: begin
        irdy_d = 1'b0;
        if (node_leaf) begin
          class_d = node_thr[CW-1:0];
          dout_d  = depth_q;
          err_d   = 1'b0;
          oval_d  = 1'b1;
          state_d = DONE;
        end else if (fidx_bad || child_bad || (depth_q == DW'(MAX_DEPTH))) begin
          class_d = '0;
          dout_d  = depth_q;
          err_d   = 1'b1;
          oval_d  = 1'b1;
          state_d = DONE;
        end else begin
          cur_d   = next_addr;
          depth_d = depth_q + DW'(1);
        end
      end

      DONE: begin
        // in_ready returns only in the cycle after the output handshake.
        if (oval_q && bus.out_ready) begin
          oval_d  = 1'b0;
          irdy_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        oval_d  = 1'b0;
        irdy_d  = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q   <= '0;
      depth_q <= '0;
      class_q <= '0;
      dout_q  <= '0;
      err_q   <= 1'b0;
      oval_q  <= 1'b0;
      irdy_q  <= 1'b1;
      rej_q   <= 1'b0;
      for (int i = 0; i < NFEAT; i++) feat_q[i] <= '0;
    end else begin
      cur_q   <= cur_d;
      depth_q <= depth_d;
      class_q <= class_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
      oval_q  <= oval_d;
      irdy_q  <= irdy_d;
      rej_q   <= rej_d;
      if (feat_ld) begin
        for (int i = 0; i < NFEAT; i++) feat_q[i] <= bus.in_feat[i*FW +: FW];
      end
    end
  end

  assign bus.in_ready  = irdy_q;
  assign bus.out_valid = oval_q;
  assign bus.out_class = class_q;
  assign bus.out_depth = dout_q;
  assign bus.out_err   = err_q;
  assign bus.cfg_rej   = rej_q;

endmodule
